usbf_tx_pkt: RTL and testbench

//  Packet transmitter that drains the device TX byte FIFO onto the UTMI transmit interface.
//  On request it sends a PID byte. For data PIDs it then sends len_i payload bytes popped from the FIFO, followed by CRC16.

---
 rtl/usbf_tx_pkt.sv | 182 ++++++++++++++++++
 tb/tb_usbf_tx_pkt.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbf_tx_pkt.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// usbf_tx_pkt
//   USB device packet transmitter. Takes a request (PID + payload length)
//   from the protocol engine, sends the PID byte on the UTMI transmit
//   interface and, for data PIDs, drains len_i payload bytes from the
//   endpoint TX FIFO followed by the CRC16 (optional).
//
//   Optional feature macro: USBF_TX_CRC_EN
//     defined   : CRC16 (0xA001 reflected, init FFFF, sent inverted LSB
//                 byte first) is appended to data packets.
//     undefined : no CRC logic; the link/PHY appends CRC itself.
//
// Ports
//   clk_i          in   clock
//   rst_i          in   asynchronous active-low reset
//   start_i        in   request pulse, sampled only in IDLE
//   pid_i[7:0]     in   PID byte (with check nibble)
//   len_i[LEN_W-1:0] in payload byte count (data PIDs only)
//   fifo_data_i    in   FIFO head byte (no read latency)
//   fifo_empty_i   in   FIFO empty
//   fifo_pop_o     out  pop FIFO head this cycle
//   utmi_data_o    out  transmit byte
//   utmi_txvalid_o out  transmit byte valid
//   utmi_txready_i in   PHY accepted byte this cycle
//   busy_o         out  packet in progress
//   done_o         out  1-cycle pulse, packet completed normally
//   underrun_o     out  1-cycle pulse, FIFO empty when a payload byte was due
// ---------------------------------------------------------------------------
module usbf_tx_pkt #(
  parameter int LEN_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

`ifdef USBF_TX_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
  } state_t;
  // State entered once the payload (possibly empty) has been sent.
  localparam state_t S_TAIL = S_CRC_LO;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_DONE
  } state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t           state_reg, state_next;
  logic [7:0]       pid_reg;
  logic [LEN_W-1:0] len_reg;
  logic             accept;
  logic             is_data;

`ifdef USBF_TX_CRC_EN
  logic [15:0] crc_reg;

  // Reflected CRC16 byte update, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction
`endif

  assign accept  = utmi_txvalid_o & utmi_txready_i;
  assign is_data = (pid_reg[1:0] == 2'b11);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      pid_reg   <= 8'h00;
      len_reg   <= '0;
`ifdef USBF_TX_CRC_EN
      crc_reg   <= 16'h0000;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start_i) begin
        pid_reg <= pid_i;
        len_reg <= len_i;
`ifdef USBF_TX_CRC_EN
        crc_reg <= 16'hFFFF;
`endif
      end
      // accept in DATA implies the FIFO was non-empty (txvalid gated).
      if (state_reg == S_DATA && accept) begin
        len_reg <= len_reg - LEN_W'(1);
`ifdef USBF_TX_CRC_EN
        crc_reg <= crc16_byte(crc_reg, fifo_data_i);
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_i) state_next = S_PID;
      S_PID: begin
        if (accept) begin
          if (!is_data)            state_next = S_DONE;
          else if (len_reg == '0)  state_next = S_TAIL;
          else                     state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (fifo_empty_i)                          state_next = S_IDLE;
        else if (accept && len_reg == LEN_W'(1))   state_next = S_TAIL;
      end
`ifdef USBF_TX_CRC_EN
      S_CRC_LO: if (accept) state_next = S_CRC_HI;
      S_CRC_HI: if (accept) state_next = S_DONE;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_pop_o     = 1'b0;
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    underrun_o     = 1'b0;
    case (state_reg)
      S_PID: begin
        busy_o         = 1'b1;
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = pid_reg;
      end
      S_DATA: begin
        busy_o = 1'b1;
        if (fifo_empty_i) begin
          underrun_o = 1'b1;
        end else begin
          utmi_txvalid_o = 1'b1;
          utmi_data_o    = fifo_data_i;
          // Pop exactly when the PHY takes the head byte.
          fifo_pop_o     = utmi_txready_i;
        end
      end
`ifdef USBF_TX_CRC_EN
      S_CRC_LO: begin
        busy_o         = 1'b1;
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_reg[7:0];
      end
      S_CRC_HI: begin
        busy_o         = 1'b1;
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_reg[15:8];
      end
`endif
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usbf_tx_pkt.sv
`timescale 1ns/1ps
module tb_usbf_tx_pkt;
  localparam int LEN_W = 7;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [7:0]       pid_i = 8'h00;
  logic [LEN_W-1:0] len_i = '0;
  logic [7:0]       fifo_data_i;
  logic             fifo_empty_i;
  logic             fifo_pop_o;
  logic [7:0]       utmi_data_o;
  logic             utmi_txvalid_o;
  logic             utmi_txready_i = 1'b0;
  logic             busy_o;
  logic             done_o;
  logic             underrun_o;

  int tests_run = 0;
  int tests_failed = 0;

  usbf_tx_pkt #(.LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pid_i(pid_i), .len_i(len_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
    .utmi_data_o(utmi_data_o), .utmi_txvalid_o(utmi_txvalid_o),
    .utmi_txready_i(utmi_txready_i), .busy_o(busy_o), .done_o(done_o),
    .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: initial block writes, pop side advances on DUT pops.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  assign fifo_data_i  = fifo_mem[rd_ptr % 256];

  // Monitor (negedge): captures accepted bytes and counts events.
  int         cyc = 0, pop_cnt = 0, done_cnt = 0, ur_cnt = 0, bad_cnt = 0;
  int         last_acc_cyc = 0, done_cyc = 0;
  logic [7:0] cap_q [$];
  bit         stall_prev = 1'b0, pop_seen = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i) begin
      if (utmi_txvalid_o && utmi_txready_i) begin
        cap_q.push_back(utmi_data_o);
        last_acc_cyc <= cyc;
      end
      if (fifo_pop_o) pop_cnt <= pop_cnt + 1;
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (underrun_o) ur_cnt <= ur_cnt + 1;
      // Protocol violations: pop without accept / on empty, stall instability,
      // txvalid together with underrun.
      if ((fifo_pop_o && !(utmi_txvalid_o && utmi_txready_i)) ||
          (fifo_pop_o && fifo_empty_i) ||
          (underrun_o && utmi_txvalid_o) ||
          (stall_prev && (!utmi_txvalid_o || utmi_data_o !== prev_data)))
        bad_cnt <= bad_cnt + 1;
      stall_prev <= utmi_txvalid_o && !utmi_txready_i;
      prev_data  <= utmi_data_o;
      pop_seen   <= fifo_pop_o;
    end else begin
      stall_prev <= 1'b0;
      pop_seen   <= 1'b0;
    end
  end

  always @(posedge clk_i) if (pop_seen) rd_ptr <= rd_ptr + 1;

  // ---------------- helpers (stimulus / reference model) ----------------
  function automatic bit rdy(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

`ifdef USBF_TX_CRC_EN
  function automatic logic [15:0] crc_of(input logic [7:0] pl [$]);
    logic [15:0] c = 16'hFFFF;
    foreach (pl[j]) begin
      for (int k = 0; k < 8; k++) begin
        bit fb;
        fb = c[0] ^ pl[j][k];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction
`endif

  task automatic build_exp(input logic [7:0] pid, input logic [7:0] pl [$],
                           output logic [7:0] exp_q [$]);
    logic [1:0] low;
    exp_q = {};
    exp_q.push_back(pid);
    low = pid[1:0];
    if (low == 2'b11) begin
      foreach (pl[j]) exp_q.push_back(pl[j]);
`ifdef USBF_TX_CRC_EN
      begin
        logic [15:0] c;
        c = ~crc_of(pl);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
      end
`endif
    end
  endtask

  function automatic int first_diff(input logic [7:0] a [$], input logic [7:0] b [$]);
    if (a.size() != b.size()) return -2;
    foreach (a[j]) if (a[j] !== b[j]) return j;
    return -1;
  endfunction

  function automatic string qstr(input logic [7:0] q [$]);
    string s = "";
    foreach (q[j]) if (j < 40) s = {s, $sformatf("%h ", q[j])};
    return s;
  endfunction

  task automatic fifo_push(input logic [7:0] pl [$]);
    foreach (pl[j]) begin
      fifo_mem[wr_ptr % 256] = pl[j];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Push payload bytes, issue a request, run until done/underrun or timeout.
  task automatic do_packet(input logic [7:0] pid, input int len, input logic [7:0] pl [$],
                           input int pct, output logic [7:0] got [$], output int pops,
                           output int dones, output int urs, output int bads,
                           output bit timeout);
    int c0, p0, d0, u0, b0;
    c0 = cap_q.size(); p0 = pop_cnt; d0 = done_cnt; u0 = ur_cnt; b0 = bad_cnt;
    fifo_push(pl);
    @(posedge clk_i); #1;
    pid_i = pid; len_i = len[LEN_W-1:0]; start_i = 1'b1; utmi_txready_i = rdy(pct);
    @(posedge clk_i); #1;
    start_i = 1'b0; pid_i = 8'($urandom); len_i = LEN_W'($urandom); utmi_txready_i = rdy(pct);
    timeout = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (done_cnt != d0 || ur_cnt != u0) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
      utmi_txready_i = rdy(pct);
    end
    utmi_txready_i = 1'b0;
    got = {};
    for (int j = c0; j < cap_q.size(); j++) got.push_back(cap_q[j]);
    pops = pop_cnt - p0; dones = done_cnt - d0; urs = ur_cnt - u0; bads = bad_cnt - b0;
    wr_ptr = rd_ptr;
    $display("[TB] pkt pid=%h len=%0d ready%%=%0d sent=%0d pops=%0d done=%0d underrun=%0d",
             pid, len, pct, got.size(), pops, dones, urs);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    tests_run++;
    if ({utmi_txvalid_o, fifo_pop_o, busy_o, done_o, underrun_o, utmi_data_o} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b pop=%b busy=%b done=%b ur=%b data=%h required all 0",
               utmi_txvalid_o, fifo_pop_o, busy_o, done_o, underrun_o, utmi_data_o);
    end
    @(posedge clk_i); #3;
    rst_i = 1'b1;
  endtask

  task automatic test_ack();
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads, d;
    bit to;
    pl = {};
    do_packet(8'hD2, $urandom_range(20, 0), pl, 100, got, pops, dones, urs, bads, to);
    exp_q = {8'hD2};
    d = first_diff(got, exp_q);
    tests_run++;
    if (to || d != -1) begin
      tests_failed++;
      $display("FAIL ack_bytes: got %s required %s timeout=%0b", qstr(got), qstr(exp_q), to);
    end
    tests_run++;
    if (pops != 0 || dones != 1 || urs != 0) begin
      tests_failed++;
      $display("FAIL ack_events: got pops=%0d done=%0d ur=%0d required 0/1/0", pops, dones, urs);
    end
    tests_run++;
    if (done_cyc != last_acc_cyc + 1) begin
      tests_failed++;
      $display("FAIL ack_done_timing: got done at cycle %0d required %0d", done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_zlp();
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads;
    bit to;
    pl = {};
    do_packet(8'h4B, 0, pl, 100, got, pops, dones, urs, bads, to);
`ifdef USBF_TX_CRC_EN
    exp_q = {8'h4B, 8'h00, 8'h00};
`else
    exp_q = {8'h4B};
`endif
    tests_run++;
    if (to || first_diff(got, exp_q) != -1) begin
      tests_failed++;
      $display("FAIL zlp_bytes: got %s required %s", qstr(got), qstr(exp_q));
    end
    tests_run++;
    if (pops != 0 || dones != 1) begin
      tests_failed++;
      $display("FAIL zlp_events: got pops=%0d done=%0d required 0/1", pops, dones);
    end
  endtask

  task automatic test_crc(input int pct, input string name);
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads;
    bit to;
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    do_packet(8'hC3, 9, pl, pct, got, pops, dones, urs, bads, to);
    build_exp(8'hC3, pl, exp_q);
    tests_run++;
    if (to || first_diff(got, exp_q) != -1) begin
      tests_failed++;
      $display("FAIL %s_bytes: got %s required %s", name, qstr(got), qstr(exp_q));
    end
`ifdef USBF_TX_CRC_EN
    tests_run++;
    if (got.size() != 12 || got[10] !== 8'hC8 || got[11] !== 8'hB4) begin
      tests_failed++;
      $display("FAIL %s_crc_value: got %s required ... c8 b4", name, qstr(got));
    end
`endif
    tests_run++;
    if (pops != 9 || dones != 1 || urs != 0 || bads != 0) begin
      tests_failed++;
      $display("FAIL %s_events: got pops=%0d done=%0d ur=%0d violations=%0d required 9/1/0/0",
               name, pops, dones, urs, bads);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads;
    bit to;
    pl = {8'($urandom), 8'($urandom)};
    do_packet(8'h4B, 4, pl, 100, got, pops, dones, urs, bads, to);
    exp_q = {8'h4B, pl[0], pl[1]};
    tests_run++;
    if (to || first_diff(got, exp_q) != -1) begin
      tests_failed++;
      $display("FAIL underrun_bytes: got %s required %s", qstr(got), qstr(exp_q));
    end
    tests_run++;
    if (urs != 1 || dones != 0 || pops != 2 || bads != 0) begin
      tests_failed++;
      $display("FAIL underrun_events: got ur=%0d done=%0d pops=%0d violations=%0d required 1/0/2/0",
               urs, dones, pops, bads);
    end
    tests_run++;
    if (busy_o !== 1'b0 || utmi_txvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_idle: got busy=%b valid=%b required 0/0", busy_o, utmi_txvalid_o);
    end
  endtask

  task automatic test_reset_restart();
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads, c0;
    bit to, busy_before;
    pl = {};
    for (int j = 0; j < 9; j++) pl.push_back(8'($urandom));
    fifo_push(pl);
    c0 = cap_q.size();
    @(posedge clk_i); #1;
    pid_i = 8'hC3; len_i = LEN_W'(9); start_i = 1'b1; utmi_txready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (cap_q.size() - c0 >= 3) begin
        to = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
    end
    busy_before = busy_o;
    #1;
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (to || busy_before !== 1'b1 ||
        {utmi_txvalid_o, fifo_pop_o, busy_o, done_o, underrun_o, utmi_data_o} !== 13'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b pop=%b busy=%b done=%b ur=%b data=%h (busy before=%b timeout=%b) required all 0",
               utmi_txvalid_o, fifo_pop_o, busy_o, done_o, underrun_o, utmi_data_o, busy_before, to);
    end
    utmi_txready_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #3;
    rst_i = 1'b1;
    wr_ptr = rd_ptr;
    $display("[TB] reset mid-DATA after %0d bytes", cap_q.size() - c0);
    pl = {};
    do_packet(8'hD2, 0, pl, 100, got, pops, dones, urs, bads, to);
    exp_q = {8'hD2};
    tests_run++;
    if (to || first_diff(got, exp_q) != -1 || dones != 1) begin
      tests_failed++;
      $display("FAIL restart_ack: got %s done=%0d required d2 done=1", qstr(got), dones);
    end
  endtask

  task automatic test_start_ignored();
    int c0, d0, p0;
    logic [7:0] got [$], exp_q [$];
    c0 = cap_q.size(); d0 = done_cnt; p0 = pop_cnt;
    fifo_mem[wr_ptr % 256] = 8'h55; wr_ptr = wr_ptr + 1;
    @(posedge clk_i); #1;
    pid_i = 8'hD2; len_i = '0; start_i = 1'b1; utmi_txready_i = 1'b0;
    @(posedge clk_i); #1;
    // Busy and stalled: a data request must be ignored.
    pid_i = 8'hC3; len_i = LEN_W'(5);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b0; utmi_txready_i = 1'b1;
    @(posedge clk_i); #1;
    // DONE cycle: request here is ignored too.
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_pulse: got done=%b required 1", done_o);
    end
    start_i = 1'b1; pid_i = 8'h4B; len_i = '0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk_i); #1;
    end
    got = {};
    for (int j = c0; j < cap_q.size(); j++) got.push_back(cap_q[j]);
    exp_q = {8'hD2};
    tests_run++;
    if (first_diff(got, exp_q) != -1 || done_cnt - d0 != 1 || pop_cnt != p0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored: got %s done=%0d pops=%0d busy=%b required d2 done=1 pops=0 busy=0",
               qstr(got), done_cnt - d0, pop_cnt - p0, busy_o);
    end
    utmi_txready_i = 1'b0;
    wr_ptr = rd_ptr;
    $display("[TB] start during busy/DONE issued, sent=%0d", got.size());
  endtask

  task automatic test_random();
    logic [7:0] got [$], exp_q [$], pl [$];
    int pops, dones, urs, bads, len, pct;
    bit to;
    logic [7:0] pid;
    for (int t = 0; t < 10; t++) begin
      pid = 8'($urandom);
      if ($urandom_range(1, 0) == 1) pid[1:0] = 2'b11;
      len = $urandom_range(20, 0);
      pct = $urandom_range(100, 30);
      pl = {};
      if (pid[1:0] == 2'b11) for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
      do_packet(pid, len, pl, pct, got, pops, dones, urs, bads, to);
      build_exp(pid, pl, exp_q);
      tests_run++;
      if (to || first_diff(got, exp_q) != -1 || pops != pl.size() || dones != 1 || urs != 0 || bads != 0) begin
        tests_failed++;
        $display("FAIL random_%0d: got %s pops=%0d done=%0d ur=%0d viol=%0d required %s pops=%0d",
                 t, qstr(got), pops, dones, urs, bads, qstr(exp_q), pl.size());
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) fifo_mem[j] = 8'h00;
    test_reset();
    test_ack();
    test_zlp();
    test_crc(100, "crc");
    test_crc(50, "backpressure");
    test_underrun();
    test_reset_restart();
    test_start_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
